// File: rtl/vending_pkg.sv
// Shared vending definitions: coin denominations, payout FSM states and the
// one-hot coin encoding used by both the intake and payout sides.
package vending_pkg;

   localparam int unsigned NumDenoms = 5;

   localparam int unsigned Denom50 = 50;
   localparam int unsigned Denom20 = 20;
   localparam int unsigned Denom10 = 10;
   localparam int unsigned Denom5  = 5;
   localparam int unsigned Denom1  = 1;

   // Bit position of each denomination inside a one-hot coin vector
   typedef enum logic [2:0] {
      IdxOne    = 3'd0,
      IdxFive   = 3'd1,
      IdxTen    = 3'd2,
      IdxTwenty = 3'd3,
      IdxFifty  = 3'd4
   } coin_idx_e;

   typedef logic [NumDenoms-1:0] coin_oh_t;

   localparam coin_oh_t CoinNone   = 5'b00000;
   localparam coin_oh_t CoinOne    = 5'b00001;
   localparam coin_oh_t CoinFive   = 5'b00010;
   localparam coin_oh_t CoinTen    = 5'b00100;
   localparam coin_oh_t CoinTwenty = 5'b01000;
   localparam coin_oh_t CoinFifty  = 5'b10000;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StIssue,
      StGap,
      StFinish,
      StFault
   } disp_state_e;

   function automatic int unsigned coin_value(input coin_oh_t coin);
      case (coin)
         CoinFifty:  return Denom50;
         CoinTwenty: return Denom20;
         CoinTen:    return Denom10;
         CoinFive:   return Denom5;
         CoinOne:    return Denom1;
         default:    return 0;
      endcase
   endfunction

endpackage

// File: rtl/denom_select.sv
// Greedy coin picker: largest denomination that fits the amount owed and is in stock.
module denom_select
   import vending_pkg::*;
#(
   parameter int unsigned AMT_W = 8
) (
   input  logic [AMT_W-1:0]     remaining_i,
   input  logic [NumDenoms-1:0] stock_nz_i,
   output logic                 valid_o,
   output coin_oh_t             coin_oh_o,
   output logic [AMT_W-1:0]     denom_o
);

   // Widen so the 50 constant compares correctly even for narrow amount widths
   localparam int unsigned CmpW = (AMT_W > 8) ? AMT_W : 8;

   logic [CmpW-1:0]      rem_ext;
   logic [NumDenoms-1:0] usable;

   assign rem_ext = CmpW'(remaining_i);

   always_comb begin
      usable            = '0;
      usable[IdxFifty]  = stock_nz_i[IdxFifty]  && (rem_ext >= CmpW'(Denom50));
      usable[IdxTwenty] = stock_nz_i[IdxTwenty] && (rem_ext >= CmpW'(Denom20));
      usable[IdxTen]    = stock_nz_i[IdxTen]    && (rem_ext >= CmpW'(Denom10));
      usable[IdxFive]   = stock_nz_i[IdxFive]   && (rem_ext >= CmpW'(Denom5));
      usable[IdxOne]    = stock_nz_i[IdxOne]    && (rem_ext >= CmpW'(Denom1));
   end

   always_comb begin
      coin_oh_o = CoinNone;
      if (usable[IdxFifty]) begin
         coin_oh_o = CoinFifty;
      end else if (usable[IdxTwenty]) begin
         coin_oh_o = CoinTwenty;
      end else if (usable[IdxTen]) begin
         coin_oh_o = CoinTen;
      end else if (usable[IdxFive]) begin
         coin_oh_o = CoinFive;
      end else if (usable[IdxOne]) begin
         coin_oh_o = CoinOne;
      end
   end

   assign valid_o = |coin_oh_o;
   assign denom_o = AMT_W'(coin_value(coin_oh_o));

endmodule

// File: rtl/change_dispenser.sv
// Vending payout engine: pays change greedily one coin at a time with a per-coin
// ack handshake, tracking per-denomination stock and flagging unpayable amounts.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int unsigned AMT_W         = 8,
   parameter int unsigned STK_W         = 6,
   parameter int unsigned INIT_STOCK_50 = 10,
   parameter int unsigned INIT_STOCK_20 = 10,
   parameter int unsigned INIT_STOCK_10 = 10,
   parameter int unsigned INIT_STOCK_5  = 10,
   parameter int unsigned INIT_STOCK_1  = 10,
   parameter int unsigned GAP_CYCLES    = 4,
   parameter int unsigned ACK_TIMEOUT   = 1000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             start,
   input  logic [AMT_W-1:0] change_amount,
   input  logic             restock,
   input  logic             coin_ack,
   output logic             out_money_fifty,
   output logic             out_money_twenty,
   output logic             out_money_ten,
   output logic             out_money_five,
   output logic             out_money_one,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [AMT_W-1:0] remaining,
   output logic [STK_W-1:0] stock_50,
   output logic [STK_W-1:0] stock_20,
   output logic [STK_W-1:0] stock_10,
   output logic [STK_W-1:0] stock_5,
   output logic [STK_W-1:0] stock_1
);

   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned AckW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [NumDenoms-1:0][STK_W-1:0] InitStock = {
      STK_W'(INIT_STOCK_50),
      STK_W'(INIT_STOCK_20),
      STK_W'(INIT_STOCK_10),
      STK_W'(INIT_STOCK_5),
      STK_W'(INIT_STOCK_1)
   };

   disp_state_e                      state_q, state_d;
   logic [AMT_W-1:0]                 rem_q, rem_d;
   coin_oh_t                         coin_q, coin_d;
   logic [AMT_W-1:0]                 denom_q, denom_d;
   logic [GapW-1:0]                  gap_cnt_q, gap_cnt_d;
   logic [AckW-1:0]                  ack_cnt_q, ack_cnt_d;
   logic [NumDenoms-1:0][STK_W-1:0]  stock_q, stock_d;

   logic [NumDenoms-1:0] stock_nz;
   logic                 sel_valid;
   coin_oh_t             sel_coin;
   logic [AMT_W-1:0]     sel_denom;

   always_comb begin
      stock_nz = '0;
      for (int i = 0; i < NumDenoms; i++) begin
         stock_nz[i] = (stock_q[i] != '0);
      end
   end

   denom_select #(
      .AMT_W (AMT_W)
   ) u_denom_select (
      .remaining_i (rem_q),
      .stock_nz_i  (stock_nz),
      .valid_o     (sel_valid),
      .coin_oh_o   (sel_coin),
      .denom_o     (sel_denom)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      coin_d    = coin_q;
      denom_d   = denom_q;
      gap_cnt_d = gap_cnt_q;
      ack_cnt_d = ack_cnt_q;
      stock_d   = stock_q;

      unique case (state_q)
         StIdle: begin
            // Restock lands this edge, so a simultaneous start selects from full stock
            if (restock) begin
               stock_d = InitStock;
            end
            if (start) begin
               rem_d   = change_amount;
               state_d = StSelect;
            end
         end

         StSelect: begin
            if (rem_q == '0) begin
               state_d = StFinish;
            end else if (!sel_valid) begin
               state_d = StFault;
            end else begin
               coin_d    = sel_coin;
               denom_d   = sel_denom;
               ack_cnt_d = '0;
               state_d   = StIssue;
            end
         end

         StIssue: begin
            if (coin_ack) begin
               coin_d = CoinNone;
               rem_d  = rem_q - denom_q;
               for (int i = 0; i < NumDenoms; i++) begin
                  if (coin_q[i] && (stock_q[i] != '0)) begin
                     stock_d[i] = stock_q[i] - 1'b1;
                  end
               end
               if (GAP_CYCLES > 0) begin
                  gap_cnt_d = '0;
                  state_d   = StGap;
               end else begin
                  state_d = StSelect;
               end
            end else if (ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
               coin_d  = CoinNone;
               state_d = StFault;
            end else begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
         end

         StGap: begin
            if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
               state_d = StSelect;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         StFinish: state_d = StIdle;

         StFault: state_d = StIdle;

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= StIdle;
         rem_q     <= '0;
         coin_q    <= CoinNone;
         denom_q   <= '0;
         gap_cnt_q <= '0;
         ack_cnt_q <= '0;
         stock_q   <= InitStock;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         coin_q    <= coin_d;
         denom_q   <= denom_d;
         gap_cnt_q <= gap_cnt_d;
         ack_cnt_q <= ack_cnt_d;
         stock_q   <= stock_d;
      end
   end

   always_comb begin
      busy  = (state_q != StIdle);
      done  = (state_q == StFinish) || (state_q == StFault);
      fault = (state_q == StFault);
   end

   assign out_money_fifty  = coin_q[IdxFifty];
   assign out_money_twenty = coin_q[IdxTwenty];
   assign out_money_ten    = coin_q[IdxTen];
   assign out_money_five   = coin_q[IdxFive];
   assign out_money_one    = coin_q[IdxOne];

   assign remaining = rem_q;
   assign stock_50  = stock_q[IdxFifty];
   assign stock_20  = stock_q[IdxTwenty];
   assign stock_10  = stock_q[IdxTen];
   assign stock_5   = stock_q[IdxFive];
   assign stock_1   = stock_q[IdxOne];

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Payout engine of the vending machine, the outgoing counterpart of the coin/note intake (one, five, ten, twenty, fifty). On a start request it pays a change amount with a greedy largest-denomination-first algorithm, one coin at a time, with a per-coin handshake to the payout mechanism. It tracks per-denomination stock and reports a fault when exact change cannot be paid. It sits between the vending control FSM (which requests the change) and the payout actuator.

Parameters:
AMT_W, 8, width of amounts and remaining counter
STK_W, 6, width of each stock counter
INIT_STOCK_50 / _20 / _10 / _5 / _1, 10 each, stock loaded on reset and on restock
GAP_CYCLES, 4, idle cycles forced between consecutive coins (0 allowed)
ACK_TIMEOUT, 1000, cycles to wait for coin_ack before fault (must be >=1)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous, active-high reset
start  in  1  request payout; sampled only in IDLE
change_amount  in  AMT_W  amount to pay; latched with start
restock  in  1  reload all stocks to INIT values; honoured only in IDLE
coin_ack  in  1  payout mechanism has released the currently requested coin
out_money_fifty / twenty / ten / five / one  out  1 each  coin request; at most one high at a time
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of every payout (success or fault)
fault  out  1  one-cycle pulse, coincident with done, on failed payout
remaining  out  AMT_W  amount still owed; for the display
stock_50 / _20 / _10 / _5 / _1  out  STK_W each  current stock

Behaviour:
- Reset: state IDLE; all coin outputs, busy, done and fault = 0; remaining = 0; stocks = INIT_STOCK_*. Reset mid-payout aborts immediately with no done pulse.
- States: IDLE, SELECT, ISSUE, GAP, FINISH, FAULT.
- IDLE: start=1 at edge N latches remaining = change_amount and moves to SELECT. busy=1 after edge N.
- SELECT (1 cycle): pick the largest d in {50,20,10,5,1} with d <= remaining and stock_d > 0.
  - remaining == 0 -> FINISH.
  - No such d -> FAULT.
  - Otherwise -> ISSUE, with the coin output for d registered high after this edge. From start, the first coin rises 2 edges later.
- ISSUE: the coin output is held until coin_ack.
  - coin_ack sampled at edge M: coin output low after M; remaining -= d; stock_d -= 1. Next state is GAP if GAP_CYCLES > 0, otherwise SELECT.
  - coin_ack absent for ACK_TIMEOUT consecutive cycles in ISSUE: drop the coin output; go to FAULT; remaining and stock unchanged.
- GAP: count GAP_CYCLES cycles, then SELECT.
- FINISH: done=1 for one cycle, then IDLE. remaining reads 0.
- FAULT: done=1 and fault=1 for one cycle, then IDLE. remaining holds the shortfall until the next start.
- Ignored inputs:
  - start while busy.
  - coin_ack outside ISSUE, including ack held high from a previous coin. Exception: coin_ack already high on the first ISSUE cycle counts as an ack.
  - restock while busy.
- Simultaneous start and restock in IDLE: restock applies first; the payout uses the reloaded stock.
- Arithmetic: subtraction never underflows because d <= remaining is guaranteed. Stock counters saturate at 0 and never wrap. All comparisons are unsigned, with denominations zero-extended to AMT_W.

Decomposition:
- Shared package (vending_pkg): denomination constants (50, 20, 10, 5, 1), the state encoding, and the one-hot coin index encoding, reused by the intake side.
- One natural sub-module: denom_select. It is combinational and takes remaining plus the five stock-nonzero flags, returning a valid flag, the one-hot coin index and the denomination value.
- The FSM, counters and stock registers stay in change_dispenser.

Test Plan:
1. Full stock, GAP_CYCLES=0, coin_ack pulsed one cycle after each request, start with amount 87 -> coins 50,20,10,5,1,1 in order; done=1 and fault=0; remaining=0; stock_50=9, stock_20=9, stock_10=9, stock_5=9, stock_1=8.
2. start with amount 0 -> no coin output; done pulse 2 cycles after start; busy for exactly 2 cycles.
3. INIT_STOCK_20=0, amount 40 -> coins 10,10,10,10; stock_10=6; no fault.
4. INIT_STOCK_1=2, INIT_STOCK_5=0, amount 3 -> coins 1,1; then done and fault together; remaining=1; stock_1=0.
5. ACK_TIMEOUT=8, amount 50, coin_ack held 0 -> out_money_fifty high for 8 cycles then low; fault pulse; remaining=50; stock_50=10.
6. start asserted again during ISSUE and sys_rst asserted mid-GAP -> second start ignored; after reset all outputs are 0, state is IDLE, stocks are reloaded to INIT values, and no done pulse occurs.
